move_exec_unit: RTL
===================

// Module: move_exec_unit
// PURPOSE
//  Parametrised register-to-register move engine for the controller datapath. Decodes the
//  move opcode group (MOV rd,rs / MVI rd,imm / XCHG rd,rs) for NUM_REGS general registers.
//  Sequences the reads and writes on the single-read / single-write register-file port pair.
//  Sits between the instruction issue stage (valid/ready) and the register file. Register 0
//  is the accumulator.
// PARAMETERS
//  DATA_W    8  register / immediate width
//  NUM_REGS  4  number of addressable registers (>=2); SEL_W = $clog2(NUM_REGS) is a localparam
//  OPCODE_W  derived localparam = 4 + 2*SEL_W (8 at defaults)
// PORTS
//  clk          in   1           system clock, all state on rising edge
//  rst          in   1           asynchronous, active-high reset
//  instr_valid  in   1           issue stage presents an opcode
//  instr_ready  out  1           unit can accept (high only in IDLE)
//  opcode       in   OPCODE_W    {group[1:0], mode[1:0], dst[SEL_W-1:0], src[SEL_W-1:0]}
//  imm          in   DATA_W      immediate for MVI, sampled with opcode
//  rd_sel       out  SEL_W       register-file read select (combinational read)
//  rd_data      in   DATA_W      register-file read data
//  wr_en        out  1           register-file write strobe
//  wr_onehot    out  NUM_REGS    one-hot destination flag, zero when wr_en=0
//  wr_sel       out  SEL_W       binary destination select
//  wr_data      out  DATA_W      write data
//  done         out  1           1-cycle pulse, instruction retired
//  illegal      out  1           1-cycle pulse, opcode not a legal move
// BEHAVIOUR
//  Reset: state=IDLE; instr_ready=1; wr_en=0, wr_onehot=0, wr_sel=0, wr_data=0, rd_sel=0,
//   done=0, illegal=0; captured dst/src/imm/tmp regs cleared. Reset mid-instruction
//   aborts it; no further writes; no done.
//  Accept on instr_valid & instr_ready (cycle N): latch mode, dst, src, imm.
//  Decode: group!=2'b01 or mode==2'b11 -> illegal. No write; state stays IDLE.
//   illegal=1 and done=1 in N+1.
//  FSM states: IDLE, MOV_W, MVI_W, XCH_RD, XCH_W1, XCH_W2.
//   MOV (mode 00): IDLE->MOV_W.
//    N+1: rd_sel=src, wr_en=1, wr_sel=dst, wr_data=rd_data, done=1, ->IDLE.
//    dst==src still performs the write.
//   MVI (mode 01): IDLE->MVI_W.
//    N+1: wr_en=1, wr_sel=dst, wr_data=imm, done=1, ->IDLE.
//   XCHG (mode 10), dst!=src:
//    N+1 XCH_RD: rd_sel=src, tmp<=rd_data.
//    N+2 XCH_W1: rd_sel=dst, write src<=rd_data.
//    N+3 XCH_W2: write dst<=tmp, done=1, ->IDLE.
//   XCHG dst==src: no write; done=1 in N+1.
//  wr_en/wr_onehot/wr_sel/wr_data/done/illegal are combinational from state + captured regs.
//   They are valid only in the cycle listed above. wr_onehot = wr_en ? (1<<wr_sel) : 0.
//  rd_sel is 0 in IDLE.
//  instr_ready=0 in every non-IDLE state. A new opcode can be accepted in the retire cycle
//   only if the FSM is back in IDLE, so throughput is 1 move per 2 cycles (XCHG: 1 per 4).
//  instr_valid while not ready is ignored. Issue stage must hold opcode/imm until accepted.
//  dst/src >= NUM_REGS (non-power-of-2 NUM_REGS) -> illegal.
// STRUCTURE
//  Shared package (move_pkg): MOVE_GROUP=2'b01, MODE_MOV/MVI/XCHG/RSVD encodings, FSM
//   state enum, field-extract functions parametrised by SEL_W. Also used by the assembler
//   tables.
//  One sub-module: move_field_decode (combinational: opcode -> mode, dst, src, legal).
//   The FSM and datapath stay in move_exec_unit.
// TESTING (defaults DATA_W=8, NUM_REGS=4, reg model R0..R3 in bench)
//  MOV R2<-R1 (opcode 8'b0100_10_01), R1=8'h5A -> N+1 wr_en=1, wr_onehot=4'b0100,
//   wr_data=8'h5A, done=1; instr_ready low only in N+1.
//  MVI R0<-imm (8'b0101_00_00, imm=8'hC3) -> N+1 wr_onehot=4'b0001, wr_data=8'hC3.
//   R1..R3 unchanged.
//  XCHG R3,R1 (8'b0110_11_01), R1=8'h11, R3=8'h22 -> N+2 write R1=8'h22,
//   N+3 write R3=8'h11, done only in N+3.
//  Illegal 8'b1000_00_00 and reserved 8'b0111_01_10 -> illegal=done=1 in N+1,
//   no wr_en ever; XCHG R2,R2 -> done in N+1, no write.
//  Back-to-back: instr_valid held high across MOV, MVI -> second accepted in cycle N+2.
//   Opcode changes while ready=0 are ignored.
//  Assert rst in XCH_W1 after XCHG accept -> no write in the following cycle, outputs at
//   reset values, instr_ready=1 after rst deasserts.

Source files
------------

// File: rtl/move_pkg.sv
// Shared definitions for the move opcode group: encodings, FSM states and
// opcode field extraction. The assembler tables use the same field helpers.
package move_pkg;

  localparam logic [1:0] MOVE_GROUP = 2'b01;
  localparam int         MAX_SEL_W  = 8;

  typedef enum logic [1:0] {
    MODE_MOV  = 2'b00,
    MODE_MVI  = 2'b01,
    MODE_XCHG = 2'b10,
    MODE_RSVD = 2'b11
  } move_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOV_W,
    ST_MVI_W,
    ST_XCH_RD,
    ST_XCH_W1,
    ST_XCH_W2
  } move_state_e;

  // Opcode layout, MSB first: {group[1:0], mode[1:0], dst[sel_w-1:0], src[sel_w-1:0]}.
  // The opcode is passed zero-extended to 32 bits so one set of helpers
  // serves every register-count configuration.
  function automatic logic [1:0] get_group(input logic [31:0] op, input int sel_w);
    logic [31:0] s;
    s = op >> (2 + 2 * sel_w);
    return s[1:0];
  endfunction

  function automatic logic [1:0] get_mode(input logic [31:0] op, input int sel_w);
    logic [31:0] s;
    s = op >> (2 * sel_w);
    return s[1:0];
  endfunction

  function automatic logic [MAX_SEL_W-1:0] get_dst(input logic [31:0] op, input int sel_w);
    logic [31:0] s;
    s = (op >> sel_w) & ((32'd1 << sel_w) - 32'd1);
    return s[MAX_SEL_W-1:0];
  endfunction

  function automatic logic [MAX_SEL_W-1:0] get_src(input logic [31:0] op, input int sel_w);
    logic [31:0] s;
    s = op & ((32'd1 << sel_w) - 32'd1);
    return s[MAX_SEL_W-1:0];
  endfunction

endpackage

// File: rtl/move_field_decode.sv
// Splits a move opcode into mode/dst/src and flags anything that is not a
// legal move (wrong group, reserved mode, register index out of range).
module move_field_decode
  import move_pkg::*;
#(
  parameter  int NUM_REGS = 4,
  localparam int SEL_W    = $clog2(NUM_REGS),
  localparam int OPCODE_W = 4 + 2 * SEL_W
) (
  input  logic [OPCODE_W-1:0] opcode,
  output move_mode_e          mode,
  output logic [SEL_W-1:0]    dst,
  output logic [SEL_W-1:0]    src,
  output logic                legal
);

  logic [31:0]          op_ext;
  logic [1:0]           group;
  logic [MAX_SEL_W-1:0] dst_w;
  logic [MAX_SEL_W-1:0] src_w;

  assign op_ext = 32'(opcode);

  // Field extraction and legality check; range check matters only for
  // non-power-of-two register counts.
  always_comb begin
    group = get_group(op_ext, SEL_W);
    mode  = move_mode_e'(get_mode(op_ext, SEL_W));
    dst_w = get_dst(op_ext, SEL_W);
    src_w = get_src(op_ext, SEL_W);
    dst   = dst_w[SEL_W-1:0];
    src   = src_w[SEL_W-1:0];
    legal = (group == MOVE_GROUP) && (mode != MODE_RSVD) &&
            (int'(dst_w) < NUM_REGS) && (int'(src_w) < NUM_REGS);
  end

endmodule

// File: rtl/move_exec_unit.sv
// Register-to-register move engine: MOV / MVI / XCHG sequenced over a single
// read port and a single write port of the register file. R0 is the
// accumulator but gets no special treatment here.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready; may emit the done/illegal pulse of a no-write op
// ST_MOV_W  | read src, write dst, retire
// ST_MVI_W  | write immediate to dst, retire
// ST_XCH_RD | read src into tmp
// ST_XCH_W1 | read dst, write it to src
// ST_XCH_W2 | write tmp to dst, retire
module move_exec_unit
  import move_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  localparam int SEL_W    = $clog2(NUM_REGS),
  localparam int OPCODE_W = 4 + 2 * SEL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [DATA_W-1:0]   imm,
  output logic [SEL_W-1:0]    rd_sel,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                wr_en,
  output logic [NUM_REGS-1:0] wr_onehot,
  output logic [SEL_W-1:0]    wr_sel,
  output logic [DATA_W-1:0]   wr_data,
  output logic                done,
  output logic                illegal
);

  move_state_e       state_q, state_d;
  logic [SEL_W-1:0]  dst_q, src_q;
  logic [DATA_W-1:0] imm_q, tmp_q;
  // Pulses for ops that retire without leaving IDLE (illegal, XCHG rX,rX).
  logic              pend_done_q, pend_done_d;
  logic              pend_ill_q, pend_ill_d;
  logic              accept;

  move_mode_e        dec_mode;
  logic [SEL_W-1:0]  dec_dst, dec_src;
  logic              dec_legal;

  move_field_decode #(.NUM_REGS(NUM_REGS)) u_decode (
    .opcode (opcode),
    .mode   (dec_mode),
    .dst    (dec_dst),
    .src    (dec_src),
    .legal  (dec_legal)
  );

  // State register, captured operands and the exchange temporary.
  // The mode itself is not kept: the state it selects carries it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dst_q       <= '0;
      src_q       <= '0;
      imm_q       <= '0;
      tmp_q       <= '0;
      pend_done_q <= 1'b0;
      pend_ill_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_done_q <= pend_done_d;
      pend_ill_q  <= pend_ill_d;
      if (accept) begin
        dst_q <= dec_dst;
        src_q <= dec_src;
        imm_q <= imm;
      end
      if (state_q == ST_XCH_RD) begin
        tmp_q <= rd_data;
      end
    end
  end

  // Next-state decode and register-file port drive for each state.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    pend_done_d = 1'b0;
    pend_ill_d  = 1'b0;
    rd_sel      = '0;
    wr_en       = 1'b0;
    wr_sel      = '0;
    wr_data     = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        done        = pend_done_q;
        illegal     = pend_ill_q;
        if (instr_valid) begin
          accept = 1'b1;
          if (!dec_legal) begin
            pend_done_d = 1'b1;
            pend_ill_d  = 1'b1;
          end else begin
            case (dec_mode)
              MODE_MOV: state_d = ST_MOV_W;
              MODE_MVI: state_d = ST_MVI_W;
              MODE_XCHG: begin
                if (dec_dst == dec_src) pend_done_d = 1'b1;
                else                    state_d     = ST_XCH_RD;
              end
              default: begin
                pend_done_d = 1'b1;
                pend_ill_d  = 1'b1;
              end
            endcase
          end
        end
      end
      ST_MOV_W: begin
        rd_sel  = src_q;
        wr_en   = 1'b1;
        wr_sel  = dst_q;
        wr_data = rd_data;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_MVI_W: begin
        wr_en   = 1'b1;
        wr_sel  = dst_q;
        wr_data = imm_q;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_XCH_RD: begin
        rd_sel  = src_q;
        state_d = ST_XCH_W1;
      end
      ST_XCH_W1: begin
        rd_sel  = dst_q;
        wr_en   = 1'b1;
        wr_sel  = src_q;
        wr_data = rd_data;
        state_d = ST_XCH_W2;
      end
      ST_XCH_W2: begin
        wr_en   = 1'b1;
        wr_sel  = dst_q;
        wr_data = tmp_q;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_onehot = wr_en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << wr_sel) : '0;

endmodule
